// File: rtl/aim_pkg.sv
`default_nettype none
// ============================================================================
// Module   : aim_pkg
// Brief    : Shared widths, ternary weight codes, activation-collector state
//            encoding and saturation helpers for the aim neuron pipeline.
// Revision : 1.0
// ============================================================================
package aim_pkg;

    // Datapath widths of the aim8 neuron and its downstream collector
    localparam int AIM_IN_W  = 12;
    localparam int AIM_OUT_W = 9;
    localparam int AIM_TW_W  = 2;
    localparam int AIM_ACC_W = 16;

    // Ternary weight encodings
    localparam logic [AIM_TW_W-1:0] AIM_TW_POS  = 2'b01;
    localparam logic [AIM_TW_W-1:0] AIM_TW_ZERO = 2'b00;
    localparam logic [AIM_TW_W-1:0] AIM_TW_NEG  = 2'b11;

    // Collector states
    typedef enum logic [0:0] {
        FILL     = 1'b0,
        WAIT_OUT = 1'b1
    } act_state_t;

    // Activation saturation limits at the default output width
    localparam int AIM_OUT_MAX = (1 << (AIM_OUT_W - 1)) - 1;
    localparam int AIM_OUT_MIN = -(1 << (AIM_OUT_W - 1));

    // Signed saturation limits for an arbitrary width (w < 32)
    function automatic int sat_max(input int w);
        return (1 << (w - 1)) - 1;
    endfunction

    function automatic int sat_min(input int w);
        return -(1 << (w - 1));
    endfunction

endpackage
`default_nettype wire

// File: rtl/aim_act_quant.sv
`default_nettype none
// ============================================================================
// Module   : aim_act_quant
// Brief    : Combinational activation quantiser: ReLU (or leaky ReLU when
//            AIM_LEAKY_RELU_EN is defined), arithmetic right shift, then
//            saturation to OUT_W signed bits with a clamp flag.
// Revision : 1.0
// ============================================================================
module aim_act_quant
    import aim_pkg::*;
#(
    parameter int ACC_W = AIM_ACC_W,
    parameter int OUT_W = AIM_OUT_W,
    parameter int SHIFT = 0
) (
    input  logic signed [ACC_W-1:0] x,
    output logic signed [OUT_W-1:0] q,
    output logic                    clamp
);

    localparam logic signed [ACC_W-1:0] C_MAX = ACC_W'(sat_max(OUT_W));
    localparam logic signed [ACC_W-1:0] C_MIN = ACC_W'(sat_min(OUT_W));

    logic                    w_pos;
    logic signed [ACC_W-1:0] w_rect;
    logic signed [ACC_W-1:0] w_shift;

    assign w_pos = !x[ACC_W-1] && (|x);

    // Rectify, scale down, then clamp into the activation range
    always_comb begin
`ifdef AIM_LEAKY_RELU_EN
        w_rect = w_pos ? x : (x >>> 3);
`else
        w_rect = w_pos ? x : '0;
`endif
        w_shift = w_rect >>> SHIFT;
        clamp   = 1'b0;
        q       = w_shift[OUT_W-1:0];
        if (w_shift > C_MAX) begin
            q     = C_MAX[OUT_W-1:0];
            clamp = 1'b1;
        end else if (w_shift < C_MIN) begin
            q     = C_MIN[OUT_W-1:0];
            clamp = 1'b1;
        end
    end

endmodule
`default_nettype wire

// File: rtl/aim_act_collect.sv
`default_nettype none
// ============================================================================
// Module   : aim_act_collect
// Brief    : Accumulates partial sums from the aim8 neuron, quantises each
//            finished neuron to a signed activation and packs N_ACT of them
//            into one output vector with valid/ready on both sides.
//            Optional macro AIM_LEAKY_RELU_EN selects leaky ReLU (slope 1/8).
// Revision : 1.0
// ============================================================================
module aim_act_collect
    import aim_pkg::*;
#(
    parameter int N_ACT = 8,
    parameter int IN_W  = AIM_IN_W,
    parameter int ACC_W = AIM_ACC_W,
    parameter int OUT_W = AIM_OUT_W,
    parameter int SHIFT = 0
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [IN_W-1:0]        in_sum,
    input  logic                   in_last,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [N_ACT*OUT_W-1:0] out_act,
    output logic                   out_sat
);

    localparam int                      COUNT_W   = (N_ACT > 1) ? $clog2(N_ACT) : 1;
    localparam logic [COUNT_W-1:0]      LAST_SLOT = COUNT_W'(N_ACT - 1);
    localparam logic signed [ACC_W-1:0] ACC_MAX   = {1'b0, {(ACC_W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] ACC_MIN   = {1'b1, {(ACC_W-1){1'b0}}};

    act_state_t              r_state;
    act_state_t              w_next_state;
    logic                    r_alive;
    logic signed [ACC_W-1:0] r_acc;
    logic [COUNT_W-1:0]      r_count;
    logic [OUT_W-1:0]        r_fill [N_ACT];

    logic                    w_xfer;
    logic                    w_fin;
    logic                    w_out_free;
    logic                    w_load;
    logic [ACC_W:0]          w_wide;
    logic signed [ACC_W-1:0] w_sum;
    logic signed [OUT_W-1:0] w_q;
    logic                    w_clamp;
    logic [N_ACT*OUT_W-1:0]  w_load_vec;

    // Ready only once out of reset and while the fill buffer is not parked
    assign in_ready   = r_alive && (r_state == FILL);
    assign w_xfer     = in_valid && in_ready;
    assign w_fin      = w_xfer && in_last;
    assign w_out_free = !out_valid || out_ready;

    // One extra bit catches overflow of the signed accumulate
    assign w_wide = {r_acc[ACC_W-1], r_acc}
                  + {{(ACC_W + 1 - IN_W){in_sum[IN_W-1]}}, in_sum};

    // Saturating accumulate
    always_comb begin
        w_sum = w_wide[ACC_W-1:0];
        if (w_wide[ACC_W] != w_wide[ACC_W-1]) begin
            w_sum = w_wide[ACC_W] ? ACC_MIN : ACC_MAX;
        end
    end

    aim_act_quant #(
        .ACC_W (ACC_W),
        .OUT_W (OUT_W),
        .SHIFT (SHIFT)
    ) u_quant (
        .x     (w_sum),
        .q     (w_q),
        .clamp (w_clamp)
    );

    // The slot being finished this cycle bypasses the fill buffer
    for (genvar gi = 0; gi < N_ACT; gi++) begin : g_pack
        assign w_load_vec[gi*OUT_W +: OUT_W] =
            ((r_state == FILL) && (r_count == COUNT_W'(gi))) ? w_q : r_fill[gi];
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= FILL;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next state and output-register load decision
    always_comb begin
        w_next_state = r_state;
        w_load       = 1'b0;
        case (r_state)
            FILL: begin
                if (w_fin && (r_count == LAST_SLOT)) begin
                    if (w_out_free) begin
                        w_load = 1'b1;
                    end else begin
                        w_next_state = WAIT_OUT;
                    end
                end
            end
            WAIT_OUT: begin
                if (out_valid && out_ready) begin
                    w_load       = 1'b1;
                    w_next_state = FILL;
                end
            end
            default: w_next_state = FILL;
        endcase
    end

    // Accumulator, fill buffer, slot counter and output register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_alive   <= 1'b0;
            r_acc     <= '0;
            r_count   <= '0;
            out_valid <= 1'b0;
            out_act   <= '0;
            out_sat   <= 1'b0;
            for (int i = 0; i < N_ACT; i++) begin
                r_fill[i] <= '0;
            end
        end else begin
            r_alive <= 1'b1;
            if (w_xfer) begin
                r_acc <= in_last ? '0 : w_sum;
            end
            if (w_fin) begin
                r_fill[r_count] <= w_q;
                if (w_clamp) begin
                    out_sat <= 1'b1;
                end
            end
            if (w_load) begin
                r_count <= '0;
            end else if (w_fin && (r_count != LAST_SLOT)) begin
                r_count <= r_count + COUNT_W'(1);
            end
            if (w_load) begin
                out_act   <= w_load_vec;
                out_valid <= 1'b1;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_aim_act_collect.sv
`default_nettype none
// ============================================================================
// Module   : tb_aim_act_collect
// Brief    : Self-checking bench for aim_act_collect against an arithmetic
//            reference model of accumulate / ReLU / shift / saturate / pack.
// Revision : 1.0
// ============================================================================
module tb_aim_act_collect;

    localparam int N_ACT  = 8;
    localparam int IN_W   = 12;
    localparam int ACC_W  = 16;
    localparam int OUT_W  = 9;
    localparam int SHIFT  = 0;
    localparam int VEC_W  = N_ACT * OUT_W;
    localparam int ACC_HI = 32767;
    localparam int ACC_LO = -32768;
    localparam int Q_HI   = 255;
    localparam int Q_LO   = -256;

    logic             clk       = 1'b0;
    logic             rst_n     = 1'b0;
    logic             in_valid  = 1'b0;
    logic             in_last   = 1'b0;
    logic [IN_W-1:0]  in_sum    = '0;
    logic             out_ready = 1'b0;
    logic             in_ready;
    logic             out_valid;
    logic             out_sat;
    logic [VEC_W-1:0] out_act;

    int n_checks  = 0;
    int n_fail    = 0;
    bit sat_model = 1'b0;

    always #5 clk = ~clk;

    aim_act_collect #(
        .N_ACT (N_ACT),
        .IN_W  (IN_W),
        .ACC_W (ACC_W),
        .OUT_W (OUT_W),
        .SHIFT (SHIFT)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_sum    (in_sum),
        .in_last   (in_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_act   (out_act),
        .out_sat   (out_sat)
    );

    // ---------------- reference model ----------------
    function automatic int quant(input int x, output bit clamp);
        int r;
`ifdef AIM_LEAKY_RELU_EN
        r = (x > 0) ? x : (x >>> 3);
`else
        r = (x > 0) ? x : 0;
`endif
        r     = r >>> SHIFT;
        clamp = 1'b0;
        if (r > Q_HI) begin r = Q_HI; clamp = 1'b1; end
        else if (r < Q_LO) begin r = Q_LO; clamp = 1'b1; end
        return r;
    endfunction

    // Expected packed vector for one vector's worth of partials
    function automatic logic [VEC_W-1:0] model_vec(input int p[$], input bit l[$]);
        int acc  = 0;
        int slot = 0;
        int q;
        bit c;
        logic [VEC_W-1:0] v = '0;
        foreach (p[i]) begin
            acc = acc + p[i];
            if (acc > ACC_HI) acc = ACC_HI;
            if (acc < ACC_LO) acc = ACC_LO;
            if (l[i]) begin
                q = quant(acc, c);
                if (c) sat_model = 1'b1;
                v[slot*OUT_W +: OUT_W] = OUT_W'(q);
                slot++;
                acc = 0;
            end
        end
        return v;
    endfunction

    // ---------------- drivers ----------------
    task automatic do_reset();
        in_valid  = 1'b0;
        in_last   = 1'b0;
        in_sum    = '0;
        out_ready = 1'b0;
        rst_n     = 1'b0;
        sat_model = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    // Called at a negedge; returns at the negedge after the transfer edge
    task automatic send(input int s, input bit last);
        int guard = 0;
        in_valid = 1'b1;
        in_sum   = IN_W'(s);
        in_last  = last;
        while (!in_ready && guard < 500) begin
            @(negedge clk);
            guard++;
        end
        if (!in_ready) begin
            n_checks++; n_fail++;
            $display("FAIL send_timeout: in_ready=%0b after %0d cycles, required 1", in_ready, guard);
        end
        @(negedge clk);
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic send_all(input int p[$], input bit l[$]);
        foreach (p[i]) send(p[i], l[i]);
    endtask

    task automatic rand_vector(output int p[$], output bit l[$]);
        p = {};
        l = {};
        for (int s = 0; s < N_ACT; s++) begin
            p.push_back(int'($urandom_range(4095, 0)) - 2048);
            l.push_back(1'b1);
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst_n = 1'b0;
        @(negedge clk);
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %0b required 0", out_valid); end
        n_checks++; if (out_act !== '0) begin n_fail++; $display("FAIL reset_out_act: got %h required 0", out_act); end
        n_checks++; if (out_sat !== 1'b0) begin n_fail++; $display("FAIL reset_out_sat: got %0b required 0", out_sat); end
        n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL reset_in_ready_low: got %0b required 0", in_ready); end
        rst_n = 1'b1;
        @(negedge clk);
        n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready_high: got %0b required 1", in_ready); end
    endtask

    task automatic test_neuron_pass();
        int a[8] = '{0, 52, -41, 0, -12, 115, 95, 0};
        int w[8] = '{1, -1, 0, 0, -1, 1, 0, -1};
        int dot = 0;
        int p[$];
        bit l[$];
        logic [VEC_W-1:0] exp_v;
        foreach (a[i]) dot += a[i] * w[i];
        p.push_back(dot); l.push_back(1'b1);
        repeat (7) begin p.push_back(0); l.push_back(1'b1); end
        do_reset();
        out_ready = 1'b1;
        exp_v = model_vec(p, l);
        for (int i = 0; i < 7; i++) send(p[i], l[i]);
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL pass_early_valid: got %0b required 0", out_valid); end
        send(p[7], l[7]);
        n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL pass_valid: got %0b required 1", out_valid); end
        n_checks++; if (out_act !== exp_v) begin n_fail++; $display("FAIL pass_act: got %h required %h", out_act, exp_v); end
        n_checks++; if (out_sat !== sat_model) begin n_fail++; $display("FAIL pass_sat: got %0b required %0b", out_sat, sat_model); end
        @(negedge clk);
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL pass_valid_drop: got %0b required 0", out_valid); end
    endtask

    task automatic test_multi_pass();
        int p[$] = '{1000, 1000, 500, 0, 0, 0, 0, 0, 0, 0};
        bit l[$] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
        logic [VEC_W-1:0] exp_v;
        do_reset();
        out_ready = 1'b1;
        exp_v = model_vec(p, l);
        send_all(p, l);
        n_checks++; if (out_act !== exp_v) begin n_fail++; $display("FAIL multi_act: got %h required %h", out_act, exp_v); end
        n_checks++; if (out_sat !== sat_model) begin n_fail++; $display("FAIL multi_sat: got %0b required %0b", out_sat, sat_model); end
    endtask

    task automatic test_negative();
        int p[$] = '{-300, -2048, -2048, -452, 0, 0, 0, 0, 0};
        bit l[$] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
        logic [VEC_W-1:0] exp_v;
        do_reset();
        out_ready = 1'b1;
        exp_v = model_vec(p, l);
        send_all(p, l);
        n_checks++; if (out_act !== exp_v) begin n_fail++; $display("FAIL neg_act: got %h required %h", out_act, exp_v); end
        n_checks++; if (out_sat !== sat_model) begin n_fail++; $display("FAIL neg_sat: got %0b required %0b", out_sat, sat_model); end
    endtask

    task automatic test_backpressure();
        int pa[$], pb[$];
        bit la[$], lb[$];
        logic [VEC_W-1:0] exp_a, exp_b;
        do_reset();
        rand_vector(pa, la);
        rand_vector(pb, lb);
        exp_a = model_vec(pa, la);
        exp_b = model_vec(pb, lb);
        send_all(pa, la);
        n_checks++; if (out_act !== exp_a) begin n_fail++; $display("FAIL bp_first_act: got %h required %h", out_act, exp_a); end
        send_all(pb, lb);
        n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_wait_ready: got %0b required 0", in_ready); end
        repeat (3) @(negedge clk);
        n_checks++; if (out_act !== exp_a) begin n_fail++; $display("FAIL bp_hold_act: got %h required %h", out_act, exp_a); end
        n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_hold_ready: got %0b required 0", in_ready); end
        out_ready = 1'b1;
        @(negedge clk);
        n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL bp_reload_valid: got %0b required 1", out_valid); end
        n_checks++; if (out_act !== exp_b) begin n_fail++; $display("FAIL bp_second_act: got %h required %h", out_act, exp_b); end
        n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL bp_resume_ready: got %0b required 1", in_ready); end
        @(negedge clk);
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL bp_valid_drop: got %0b required 0", out_valid); end
        n_checks++; if (out_sat !== sat_model) begin n_fail++; $display("FAIL bp_sat: got %0b required %0b", out_sat, sat_model); end
    endtask

    task automatic test_reset_mid();
        int pa[$], pb[$];
        bit la[$], lb[$];
        logic [VEC_W-1:0] exp_b;
        do_reset();
        for (int i = 0; i < N_ACT; i++) begin pa.push_back(2047); la.push_back(1'b1); end
        send_all(pa, la);
        for (int i = 0; i < 5; i++) send(int'($urandom_range(2047, 1)), 1'b1);
        #3;
        rst_n = 1'b0;
        #1;
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rmid_valid: got %0b required 0", out_valid); end
        n_checks++; if (out_act !== '0) begin n_fail++; $display("FAIL rmid_act: got %h required 0", out_act); end
        n_checks++; if (out_sat !== 1'b0) begin n_fail++; $display("FAIL rmid_sat: got %0b required 0", out_sat); end
        sat_model = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        out_ready = 1'b1;
        rand_vector(pb, lb);
        exp_b = model_vec(pb, lb);
        send_all(pb, lb);
        n_checks++; if (out_act !== exp_b) begin n_fail++; $display("FAIL rmid_fresh_act: got %h required %h", out_act, exp_b); end
    endtask

    task automatic test_acc_sat();
        int p[$];
        bit l[$];
        logic [VEC_W-1:0] exp_v;
        repeat (20) begin p.push_back(2047); l.push_back(1'b0); end
        repeat (8) begin p.push_back(0); l.push_back(1'b1); end
        do_reset();
        out_ready = 1'b1;
        n_checks++; if (out_sat !== 1'b0) begin n_fail++; $display("FAIL accsat_pre_sat: got %0b required 0", out_sat); end
        exp_v = model_vec(p, l);
        send_all(p, l);
        n_checks++; if (out_act !== exp_v) begin n_fail++; $display("FAIL accsat_act: got %h required %h", out_act, exp_v); end
        n_checks++; if (out_sat !== sat_model) begin n_fail++; $display("FAIL accsat_sat: got %0b required %0b", out_sat, sat_model); end
    endtask

    task automatic test_random();
        localparam int NV = 20;
        int p[$], vp[$];
        bit l[$], vl[$];
        logic [VEC_W-1:0] expq[$];
        logic [VEC_W-1:0] exp_v;
        int got = 0;
        int cyc = 0;
        int n;
        do_reset();
        for (int v = 0; v < NV; v++) begin
            vp = {};
            vl = {};
            for (int s = 0; s < N_ACT; s++) begin
                n = int'($urandom_range(4, 1));
                for (int k = 0; k < n; k++) begin
                    vp.push_back(int'($urandom_range(4095, 0)) - 2048);
                    vl.push_back(k == n - 1);
                end
            end
            expq.push_back(model_vec(vp, vl));
            p = {p, vp};
            l = {l, vl};
        end
        fork
            begin
                foreach (p[i]) send(p[i], l[i]);
            end
            begin
                while (got < NV && cyc < 20000) begin
                    @(negedge clk);
                    cyc++;
                    out_ready = ($urandom_range(3, 0) != 0);
                    if (out_valid && out_ready) begin
                        exp_v = expq.pop_front();
                        n_checks++;
                        if (out_act !== exp_v) begin
                            n_fail++;
                            $display("FAIL rand_vec%0d: got %h required %h", got, out_act, exp_v);
                        end
                        got++;
                    end
                end
            end
        join
        out_ready = 1'b1;
        n_checks++; if (got != NV) begin n_fail++; $display("FAIL rand_count: got %0d vectors required %0d", got, NV); end
        n_checks++; if (out_sat !== sat_model) begin n_fail++; $display("FAIL rand_sat: got %0b required %0b", out_sat, sat_model); end
    endtask

    initial begin
        test_reset();
        test_neuron_pass();
        test_multi_pass();
        test_negative();
        test_backpressure();
        test_reset_mid();
        test_acc_sat();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
